// File: rtl/datapath_registers.sv
// Architectural and inter-cycle state of the multicycle RV32I core:
// PC, old PC, IR, MDR, A/B operand latches, ALUOut and the 32x32 register file.
// All sequencing comes from the external control unit strobes.
module datapath_registers #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        branch_taken,
    input  logic        pc_source,
    input  logic        ir_write,
    input  logic        reg_write,
    input  logic        lorD,
    input  logic        memory_to_reg,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] old_pc,
    output logic [31:0] instruction,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] reg_a,
    output logic [31:0] reg_b,
    output logic [31:0] alu_out,
    output logic [31:0] mdr,
    output logic [31:0] mem_addr
);

    logic [31:0] rf [0:31];

    logic        pc_en;
    logic [31:0] pc_next;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;

    // Decode fields, PC/address muxes and register-file read ports from the current IR.
    always_comb begin
        opcode   = instruction[6:0];
        rd       = instruction[11:7];
        funct3   = instruction[14:12];
        funct7   = instruction[31:25];
        rs1      = instruction[19:15];
        rs2      = instruction[24:20];
        pc_en    = pc_write | (pc_write_cond & branch_taken);
        pc_next  = pc_source ? alu_out : alu_result;
        mem_addr = lorD ? alu_out : pc;
        wb_data  = memory_to_reg ? mdr : alu_out;
        rs1_data = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
        rs2_data = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
    end

    // PC, IR/old_pc and the free-running MDR/ALUOut/A/B latches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            old_pc      <= 32'd0;
            instruction <= NOP_INSTR;
            mdr         <= 32'd0;
            alu_out     <= 32'd0;
            reg_a       <= 32'd0;
            reg_b       <= 32'd0;
        end else begin
            // Bit 0 is forced low so JALR targets are always halfword aligned.
            if (pc_en) begin
                pc <= {pc_next[31:1], 1'b0};
            end
            // old_pc takes the pre-update pc, so FETCH records the fetched address.
            if (ir_write) begin
                instruction <= mem_rdata;
                old_pc      <= pc;
            end
            mdr     <= mem_rdata;
            alu_out <= alu_result;
            // No bypass: a same-edge write to rs1/rs2 leaves A/B with the old value.
            reg_a   <= rs1_data;
            reg_b   <= rs2_data;
        end
    end

    // Register file write port; x0 is never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'd0;
            end
        end else if (reg_write && (rd != 5'd0)) begin
            rf[rd] <= wb_data;
        end
    end

endmodule

// File: tb/tb_datapath_registers.sv
// Directed testbench for datapath_registers.
module tb_datapath_registers;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch_taken;
    logic        pc_source;
    logic        ir_write;
    logic        reg_write;
    logic        lorD;
    logic        memory_to_reg;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic [31:0] old_pc;
    logic [31:0] instruction;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [31:0] alu_out;
    logic [31:0] mdr;
    logic [31:0] mem_addr;

    int checks;
    int errors;

    datapath_registers dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .branch_taken (branch_taken),
        .pc_source    (pc_source),
        .ir_write     (ir_write),
        .reg_write    (reg_write),
        .lorD         (lorD),
        .memory_to_reg(memory_to_reg),
        .alu_result   (alu_result),
        .mem_rdata    (mem_rdata),
        .pc           (pc),
        .old_pc       (old_pc),
        .instruction  (instruction),
        .opcode       (opcode),
        .rd           (rd),
        .funct3       (funct3),
        .funct7       (funct7),
        .reg_a        (reg_a),
        .reg_b        (reg_b),
        .alu_out      (alu_out),
        .mdr          (mdr),
        .mem_addr     (mem_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_taken  = 1'b0;
        pc_source     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        lorD          = 1'b0;
        memory_to_reg = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        pc_write      = 1'b1;
        pc_write_cond = 1'b1;
        branch_taken  = 1'b1;
        pc_source     = 1'b1;
        ir_write      = 1'b1;
        reg_write     = 1'b1;
        lorD          = 1'b1;
        memory_to_reg = 1'b1;
        alu_result    = 32'hFFFF_FFFF;
        mem_rdata     = 32'hFFFF_FFFF;
        tick();
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
        checks++; if (instruction !== 32'h13) begin errors++; $display("FAIL reset_ir got %h want %h", instruction, 32'h13); end
        checks++; if (old_pc !== 32'h0) begin errors++; $display("FAIL reset_old_pc got %h want %h", old_pc, 32'h0); end
        checks++; if (alu_out !== 32'h0 || mdr !== 32'h0) begin errors++; $display("FAIL reset_aluout_mdr got %h %h want 0 0", alu_out, mdr); end
        checks++; if (reg_a !== 32'h0 || reg_b !== 32'h0) begin errors++; $display("FAIL reset_ab got %h %h want 0 0", reg_a, reg_b); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want %h", mem_addr, 32'h0); end
        idle();
        alu_result = 32'h0;
        mem_rdata  = 32'h0;
        rst_n      = 1'b1;
        tick();
        checks++; if (pc !== 32'h0 || mem_addr !== 32'h0) begin errors++; $display("FAIL post_reset_pc got %h %h want 0 0", pc, mem_addr); end
        // Every register reads zero after reset.
        for (int i = 1; i < 32; i++) begin
            mem_rdata = (32'(i) << 20) | (32'(i) << 15) | 32'h33;
            ir_write  = 1'b1;
            tick();
            ir_write  = 1'b0;
            tick();
            checks++;
            if (reg_a !== 32'h0 || reg_b !== 32'h0) begin
                errors++;
                $display("FAIL reset_rf_x%0d got %h %h want 0 0", i, reg_a, reg_b);
            end
        end
    endtask

    task automatic test_fetch();
        idle();
        alu_result = 32'h10;
        pc_write   = 1'b1;
        tick();
        checks++; if (pc !== 32'h10 || old_pc !== 32'h0) begin errors++; $display("FAIL set_pc got %h %h want 10 0", pc, old_pc); end
        mem_rdata  = 32'h0050_0093;
        alu_result = 32'h14;
        pc_write   = 1'b1;
        ir_write   = 1'b1;
        tick();
        checks++; if (pc !== 32'h14) begin errors++; $display("FAIL fetch_pc got %h want %h", pc, 32'h14); end
        checks++; if (old_pc !== 32'h10) begin errors++; $display("FAIL fetch_old_pc got %h want %h", old_pc, 32'h10); end
        checks++; if (instruction !== 32'h0050_0093) begin errors++; $display("FAIL fetch_ir got %h want %h", instruction, 32'h0050_0093); end
        checks++; if (rd !== 5'd1 || opcode !== 7'h13 || funct3 !== 3'd0 || funct7 !== 7'h0) begin
            errors++; $display("FAIL fetch_fields got rd=%0d op=%h f3=%0d f7=%h want 1 13 0 0", rd, opcode, funct3, funct7);
        end
        mem_rdata  = 32'h40C5_D533;
        alu_result = 32'h18;
        tick();
        checks++; if (pc !== 32'h18 || old_pc !== 32'h14) begin errors++; $display("FAIL fetch2_pc got %h %h want 18 14", pc, old_pc); end
        checks++; if (rd !== 5'd10 || opcode !== 7'h33 || funct3 !== 3'd5 || funct7 !== 7'h20) begin
            errors++; $display("FAIL fetch2_fields got rd=%0d op=%h f3=%0d f7=%h want 10 33 5 20", rd, opcode, funct3, funct7);
        end
        idle();
        mem_rdata = 32'h1234_5678;
        tick();
        checks++; if (instruction !== 32'h40C5_D533 || pc !== 32'h18 || old_pc !== 32'h14) begin
            errors++; $display("FAIL hold_ir_pc got %h %h %h want 40c5d533 18 14", instruction, pc, old_pc);
        end
    endtask

    task automatic test_branch();
        idle();
        alu_result = 32'h40;
        tick();
        checks++; if (alu_out !== 32'h40) begin errors++; $display("FAIL aluout_latch got %h want %h", alu_out, 32'h40); end
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        branch_taken  = 1'b0;
        tick();
        checks++; if (pc !== 32'h18) begin errors++; $display("FAIL branch_not_taken got %h want %h", pc, 32'h18); end
        pc_write_cond = 1'b0;
        branch_taken  = 1'b1;
        tick();
        checks++; if (pc !== 32'h18) begin errors++; $display("FAIL branch_no_cond got %h want %h", pc, 32'h18); end
        pc_write_cond = 1'b1;
        tick();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL branch_taken got %h want %h", pc, 32'h40); end
        idle();
        alu_result = 32'h81;
        pc_write   = 1'b1;
        tick();
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL pc_bit0_alu_result got %h want %h", pc, 32'h80); end
        idle();
        alu_result = 32'h41;
        tick();
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        branch_taken  = 1'b1;
        tick();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL pc_bit0_alu_out got %h want %h", pc, 32'h40); end
        idle();
    endtask

    task automatic test_write_back();
        idle();
        mem_rdata = 32'h0002_82B3;
        ir_write  = 1'b1;
        tick();
        ir_write  = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        checks++; if (mdr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mdr_latch got %h want %h", mdr, 32'hDEAD_BEEF); end
        reg_write     = 1'b1;
        memory_to_reg = 1'b1;
        tick();
        reg_write = 1'b0;
        tick();
        checks++; if (reg_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wb_mdr_x5 got %h want %h", reg_a, 32'hDEAD_BEEF); end
        alu_result    = 32'h1234;
        memory_to_reg = 1'b0;
        tick();
        reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
        tick();
        checks++; if (reg_a !== 32'h1234) begin errors++; $display("FAIL wb_aluout_x5 got %h want %h", reg_a, 32'h1234); end
        mem_rdata = 32'h0000_0033;
        ir_write  = 1'b1;
        tick();
        ir_write      = 1'b0;
        mem_rdata     = 32'hDEAD_BEEF;
        tick();
        reg_write     = 1'b1;
        memory_to_reg = 1'b1;
        tick();
        reg_write = 1'b0;
        tick();
        checks++; if (reg_a !== 32'h0 || reg_b !== 32'h0) begin errors++; $display("FAIL wb_x0 got %h %h want 0 0", reg_a, reg_b); end
        idle();
    endtask

    task automatic test_collision();
        idle();
        mem_rdata = 32'h0031_81B3;
        ir_write  = 1'b1;
        tick();
        ir_write   = 1'b0;
        alu_result = 32'h11;
        tick();
        reg_write = 1'b1;
        tick();
        reg_write  = 1'b0;
        alu_result = 32'h99;
        tick();
        checks++; if (reg_a !== 32'h11 || reg_b !== 32'h11) begin errors++; $display("FAIL coll_setup got %h %h want 11 11", reg_a, reg_b); end
        reg_write = 1'b1;
        tick();
        checks++; if (reg_a !== 32'h11 || reg_b !== 32'h11) begin errors++; $display("FAIL coll_old got %h %h want 11 11", reg_a, reg_b); end
        reg_write = 1'b0;
        tick();
        checks++; if (reg_a !== 32'h99 || reg_b !== 32'h99) begin errors++; $display("FAIL coll_new got %h %h want 99 99", reg_a, reg_b); end
        idle();
    endtask

    task automatic test_addr_and_reset();
        idle();
        alu_result = 32'h200;
        tick();
        lorD = 1'b1;
        #1;
        checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL mem_addr_aluout got %h want %h", mem_addr, 32'h200); end
        lorD = 1'b0;
        #1;
        checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL mem_addr_pc got %h want %h", mem_addr, 32'h40); end
        pc_write   = 1'b1;
        ir_write   = 1'b1;
        reg_write  = 1'b1;
        alu_result = 32'h300;
        mem_rdata  = 32'h0031_81B3;
        rst_n      = 1'b0;
        tick();
        checks++; if (pc !== 32'h0 || instruction !== 32'h13 || alu_out !== 32'h0) begin
            errors++; $display("FAIL mid_reset got %h %h %h want 0 13 0", pc, instruction, alu_out);
        end
        idle();
        rst_n = 1'b1;
        tick();
        checks++; if (pc !== 32'h0 || mem_addr !== 32'h0) begin errors++; $display("FAIL after_mid_reset got %h %h want 0 0", pc, mem_addr); end
        ir_write = 1'b1;
        tick();
        ir_write = 1'b0;
        tick();
        checks++; if (reg_a !== 32'h0 || reg_b !== 32'h0) begin errors++; $display("FAIL rf_cleared_x3 got %h %h want 0 0", reg_a, reg_b); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        alu_result = 32'h0;
        mem_rdata  = 32'h0;
        idle();
        test_reset();
        test_fetch();
        test_branch();
        test_write_back();
        test_collision();
        test_addr_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_registers.md
Name: datapath_registers

Overview:
- Architectural and inter-cycle state of the multicycle RV32I core: PC, old PC, instruction register (IR), memory data register (MDR), operand registers A/B, ALUOut, and the 32x32 register file.
- Sits directly downstream of the control unit and consumes its strobes: pc_write, pc_write_cond, pc_source, ir_write, reg_write, lorD, memory_to_reg.
- Supplies the ALU operand muxes, the memory address port and the decoded instruction fields.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, IR value loaded on reset (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- pc_write  in  1  unconditional PC update.
- pc_write_cond  in  1  PC update only when branch_taken=1.
- branch_taken  in  1  branch condition result from the ALU/comparator.
- pc_source  in  1  PC next-value select: 0 = alu_result, 1 = alu_out register.
- ir_write  in  1  load IR from mem_rdata and capture old_pc.
- reg_write  in  1  register-file write enable.
- lorD  in  1  memory address select: 0 = pc, 1 = alu_out.
- memory_to_reg  in  1  write-back select: 0 = alu_out, 1 = mdr.
- alu_result  in  32  combinational ALU output.
- mem_rdata  in  32  memory read data.
- pc  out  32  current PC register.
- old_pc  out  32  PC of the instruction held in IR.
- instruction  out  32  IR contents.
- opcode  out  7  IR[6:0].
- rd  out  5  IR[11:7].
- funct3  out  3  IR[14:12].
- funct7  out  7  IR[31:25].
- reg_a  out  32  A register.
- reg_b  out  32  B register.
- alu_out  out  32  ALUOut register.
- mdr  out  32  MDR register.
- mem_addr  out  32  combinational; lorD ? alu_out : pc.

Behaviour:
- Reset (rst_n=0 at a rising edge) loads:
  - pc = RESET_PC, instruction = NOP_INSTR.
  - old_pc, reg_a, reg_b, alu_out, mdr = 0.
  - All 32 register-file entries = 0.
  - Reset has priority over every enable.
- A reset asserted mid-instruction discards the instruction; the first cycle after rst_n rises sees pc = RESET_PC.
- PC update:
  - pc_en = pc_write | (pc_write_cond & branch_taken).
  - When pc_en=1: pc <= {next[31:1],1'b0}, where next = pc_source ? alu_out : alu_result. Bit 0 is always cleared, as JALR requires.
  - When pc_en=0: pc holds, whatever the value of branch_taken.
- IR/old_pc: when ir_write=1, instruction <= mem_rdata and old_pc <= pc, using the pre-update pc. This holds even when pc_write=1 in the same cycle (FETCH). Otherwise both hold.
- Free-running latches, updated every non-reset cycle:
  - mdr <= mem_rdata.
  - alu_out <= alu_result.
  - reg_a <= RF[IR[19:15]].
  - reg_b <= RF[IR[24:20]].
- Register-file reads are combinational from the current IR; reads of x0 return 0.
- Register-file write:
  - When reg_write=1 and rd != 0: RF[rd] <= memory_to_reg ? mdr : alu_out.
  - Writes to x0 are discarded.
- Write/latch collision: a write and an A/B latch of the same register on the same edge give A/B the OLD value. There is no bypass; the multicycle schedule never needs one.
- Latency:
  - Strobe to pc/IR/RF visible: 1 cycle.
  - mem_addr and the decoded fields: 0 cycles (combinational).
- No internal FSM; sequencing belongs entirely to the control unit. Stable enables hold all gated state indefinitely.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with all strobes =1 -> pc=0, instruction=32'h13, RF[1..31]=0, mem_addr=0.
- Fetch: pc=0x10, mem_rdata=32'h00500093, alu_result=0x14, pc_write=ir_write=1 -> next cycle pc=0x14, old_pc=0x10, instruction=32'h00500093, rd=1, opcode=7'h13.
- Branch: pc_write_cond=1, pc_source=1, alu_out=0x40:
  - branch_taken=0 -> pc unchanged.
  - branch_taken=1 -> pc=0x40.
  - alu_out=0x41 -> pc=0x40 (bit 0 cleared).
- Write-back: reg_write=1, rd=5:
  - memory_to_reg=1, mdr=0xDEADBEEF -> RF[5]=0xDEADBEEF.
  - rd=0 -> x0 still reads 0.
- Collision: same edge writes x3=0x99 (old value 0x11) and latches A from rs1=3 -> reg_a=0x11; one cycle later reg_a=0x99.
- Address mux and mid-operation reset: lorD=1, alu_out=0x200 -> mem_addr=0x200; lorD=0 -> mem_addr=pc. Then rst_n=0 -> pc=RESET_PC.
